alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, multi-cycle successor to the execute-stage ALU. It performs single-cycle arithmetic and logical operations on `DATA_WIDTH` operands, plus an iterative signed multiply (low and high half) with a busy/done handshake. Results and flags are registered, and a sticky overflow flag is kept. It sits in the execute stage between the crossbar (`xb_*`) and the program sequencer (`ps_*`).

## Interface
- `DATA_WIDTH`, default 16: operand/result width in bits; must be ≥ 4.
- `clk_exe`  in  1  execute clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ps_alu_en`  in  1  operation request; accepted only when `alu_ps_busy`=0.
- `ps_alu_op`  in  4  opcode, sampled on accept.
- `ps_alu_sat`  in  1  saturation enable, sampled on accept.
- `ps_alu_ci`  in  1  carry in for ADDC/SUBB, sampled on accept.
- `ps_alu_clr`  in  1  clears `alu_ps_avs`; takes priority over a same-cycle set.
- `xb_dtx`, `xb_dty`  in  DATA_WIDTH  operands X and Y, sampled on accept.
- `alu_xb_dt`  out  DATA_WIDTH  registered result.
- `alu_ps_done`  out  1  one-cycle pulse when `alu_xb_dt` and the flags update.
- `alu_ps_busy`  out  1  multiply in progress.
- `alu_ps_az`, `alu_ps_an`, `alu_ps_ac`, `alu_ps_av`  out  1  zero, negative, carry and overflow flags; registered with the result.
- `alu_ps_avs`  out  1  sticky OR of `alu_ps_av`.
- `alu_ps_compd`  out  1  high with `alu_ps_done` when the completed op was COMP.

## Operation
- **Opcodes:**
  - 0 ADD x+y
  - 1 SUB x+~y+1
  - 2 ADDC x+y+ci
  - 3 SUBB x+~y+ci
  - 4 COMP: result all-ones if x<y (signed), 0 if x==y, 1 otherwise
  - 5 MIN (signed)
  - 6 MAX (signed)
  - 7 NEG: ~x+1
  - 8 ABS: x, or ~x+1 if x is negative
  - 9 AND
  - A OR
  - B XOR
  - C NOT x
  - D MUL: signed, low half
  - E MULH: signed, high half
  - F reserved: result 0, all flags 0
- **Flags, all ops:** `az` = (result==0), `an` = result MSB, both computed after saturation.
- **`ac`:** carry out of the W-bit adder for ops 0-3, 7 and 8; 0 for all other ops.
- **`av`:** (carry into MSB) XOR (carry out of MSB) for ops 0-3, 7 and 8.
  - NEG and ABS of the minimum value (`1<<(W-1)`) therefore set `av`.
  - For MUL, `av`=1 when the 2W-bit signed product is outside the W-bit signed range.
  - `av`=0 for all other ops.
- **Saturation (ops 0-3, 7, 8, D):** when sat=1 and av=1, the result is the signed max (`0111…1`) if the true result is positive, else the signed min (`1000…0`). `av` still reports the unsaturated overflow.
- **`alu_ps_avs`:** set on any done with av=1; cleared only by `ps_alu_clr` or reset.
- **State machine:** states IDLE, MUL, FIX.
  - IDLE: accepting a non-multiply op computes from the inputs and registers the result and flags at the same edge. The FSM stays in IDLE.
  - IDLE: accepting D or E loads |x| and |y| (unsigned, W bits, so that `-2^(W-1)` becomes `2^(W-1)`), latches the sign XOR, clears the 2W-bit product, loads the step counter to W, and moves to MUL.
  - MUL: radix-2 shift-add, one multiplier bit per cycle, counter decremented; after W cycles the FSM moves to FIX.
  - FIX: negate the product if the sign XOR is 1, select the low or high half, apply the overflow/saturation rules, register the result and flags, pulse done, return to IDLE.
- `ps_alu_en` while busy is ignored. It is not queued and has no effect on state or outputs.
- Outputs hold their values between done pulses.
- **Reset (including mid-multiply):** state returns to IDLE. All outputs, including `alu_xb_dt`, all flags, `alu_ps_avs`, busy and done, go to 0. The internal product and counter go to 0. Any in-flight multiply is discarded.

## Timing
- Accept edge = the rising edge with `ps_alu_en`=1 and `alu_ps_busy`=0.
- **Single-cycle op accepted at edge N:** result and flags are valid after N, and `alu_ps_done`=1 for the cycle N→N+1. Back-to-back accepts on every edge are legal.
- **MUL/MULH accepted at edge N:**
  - `alu_ps_busy`=1 from after N until after N+W+1.
  - The result registers at N+W+1, and `alu_ps_done`=1 for the cycle N+W+1→N+W+2.
  - Latency is W+1 cycles, i.e. 17 cycles for W=16.
- A new accept is possible at edge N+W+2.
- `alu_ps_busy` and `alu_ps_done` are never high in the same cycle.
- `alu_ps_clr` at a done edge with av=1: `alu_ps_avs` ends at 0.

## Test plan
- **ADD with and without saturation:** ADD 0x7FFF+0x0001, sat=0 → 0x8000, av=1, an=1, ac=0, avs=1. The same with sat=1 → 0x7FFF, av=1.
- **SUB to zero and COMP:** SUB 0x0005−0x0005 → 0x0000, az=1, ac=1, av=0. COMP 0x8000 vs 0x0001 → 0xFFFF, an=1, compd=1, ac=av=0.
- **Signed multiply timing:** MUL 0x0003×0xFFFB → 0xFFF1, an=1, av=0. Busy lasts 17 cycles and done pulses once, 17 edges after accept.
- **Multiply overflow and high half:** MUL 0x0100×0x0100, sat=1 → 0x7FFF, av=1. MULH on the same operands → 0x0001, av=0. MUL 0x8000×0x8000, sat=1 → 0x7FFF.
- **Requests while busy:** pulse `ps_alu_en` with ADD during a MUL. The ADD is ignored, the MUL result is unaffected, and only one done pulse occurs.
- **Reset and sticky clear:** assert `reset` at iteration 8 of a MUL → all outputs 0, state IDLE. After release, an ADD 0x0001+0x0001 → 0x0002 with done one edge later. `ps_alu_clr` clears `alu_ps_avs`.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU with registered results and flags.
// Single-cycle arith/logic ops plus an iterative signed multiply.
module alu_seq #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_exe,
  input  logic                  reset,
  input  logic                  ps_alu_en,
  input  logic [3:0]            ps_alu_op,
  input  logic                  ps_alu_sat,
  input  logic                  ps_alu_ci,
  input  logic                  ps_alu_clr,
  input  logic [DATA_WIDTH-1:0] xb_dtx,
  input  logic [DATA_WIDTH-1:0] xb_dty,
  output logic [DATA_WIDTH-1:0] alu_xb_dt,
  output logic                  alu_ps_done,
  output logic                  alu_ps_busy,
  output logic                  alu_ps_az,
  output logic                  alu_ps_an,
  output logic                  alu_ps_ac,
  output logic                  alu_ps_av,
  output logic                  alu_ps_avs,
  output logic                  alu_ps_compd
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIX
  } state_t;

  state_t state, state_nx;

  logic [2*W-1:0] mcand, prod, pfix;
  logic [W-1:0]   mplier, ax, ay;
  logic [CW-1:0]  cnt;
  logic           sgn, hi_q, sat_q;

  logic           accept, is_mul, lt;
  logic [W-1:0]   add_a, add_b;
  logic           add_c, arith;
  logic [W:0]     sum;
  logic           cout, ovf;

  logic [W-1:0]   s_res, m_res, n_res;
  logic           s_ac, s_av, s_zv, m_av;
  logic           upd, n_ac, n_av, n_zv;

  assign accept = ps_alu_en && (state == IDLE);
  assign is_mul = (ps_alu_op == 4'hD) || (ps_alu_op == 4'hE);
  assign lt     = $signed(xb_dtx) < $signed(xb_dty);
  assign ax     = xb_dtx[W-1] ? -xb_dtx : xb_dtx;
  assign ay     = xb_dty[W-1] ? -xb_dty : xb_dty;
  assign alu_ps_busy = (state != IDLE);

  // Adder operand selection; NEG/ABS reuse the adder as ~x + 1.
  always_comb begin
    add_a = xb_dtx;
    add_b = '0;
    add_c = 1'b0;
    arith = 1'b1;
    unique case (ps_alu_op)
      4'h0: add_b = xb_dty;
      4'h1: begin
        add_b = ~xb_dty;
        add_c = 1'b1;
      end
      4'h2: begin
        add_b = xb_dty;
        add_c = ps_alu_ci;
      end
      4'h3: begin
        add_b = ~xb_dty;
        add_c = ps_alu_ci;
      end
      4'h7: begin
        add_a = ~xb_dtx;
        add_c = 1'b1;
      end
      4'h8: begin
        if (xb_dtx[W-1]) begin
          add_a = ~xb_dtx;
          add_c = 1'b1;
        end
      end
      default: arith = 1'b0;
    endcase
  end

  assign sum  = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_c};
  assign cout = sum[W];
  // Carry into the MSB recovered from the MSB sum bit.
  assign ovf  = sum[W-1] ^ add_a[W-1] ^ add_b[W-1] ^ cout;

  // Single-cycle result, saturation and flag sources.
  always_comb begin
    s_res = '0;
    s_ac  = 1'b0;
    s_av  = 1'b0;
    s_zv  = 1'b1;
    if (arith) begin
      s_res = sum[W-1:0];
      s_ac  = cout;
      s_av  = ovf;
      if (ps_alu_sat && ovf)
        s_res = sum[W-1] ? MAXV : MINV;
    end else begin
      unique case (ps_alu_op)
        4'h4: s_res = lt ? '1 :
                      (xb_dtx == xb_dty) ? '0 : ONE;
        4'h5: s_res = lt ? xb_dtx : xb_dty;
        4'h6: s_res = lt ? xb_dty : xb_dtx;
        4'h9: s_res = xb_dtx & xb_dty;
        4'hA: s_res = xb_dtx | xb_dty;
        4'hB: s_res = xb_dtx ^ xb_dty;
        4'hC: s_res = ~xb_dtx;
        default: s_zv = 1'b0;
      endcase
    end
  end

  // Multiply fix-up: apply sign, pick half, detect overflow.
  always_comb begin
    pfix  = sgn ? -prod : prod;
    m_av  = 1'b0;
    m_res = pfix[W-1:0];
    if (hi_q) begin
      m_res = pfix[2*W-1:W];
    end else begin
      m_av = ~(&pfix[2*W-1:W-1]) &
             (|pfix[2*W-1:W-1]);
      if (sat_q && m_av)
        m_res = sgn ? MINV : MAXV;
    end
  end

  // Select which completion updates the outputs this edge.
  always_comb begin
    upd   = (accept && !is_mul) || (state == FIX);
    n_res = s_res;
    n_ac  = s_ac;
    n_av  = s_av;
    n_zv  = s_zv;
    if (state == FIX) begin
      n_res = m_res;
      n_ac  = 1'b0;
      n_av  = m_av;
      n_zv  = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_exe or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept && is_mul) state_nx = MUL;
      MUL:  if (cnt == CW'(1))     state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shift-add multiplier datapath.
  always_ff @(posedge clk_exe or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      sgn    <= 1'b0;
      hi_q   <= 1'b0;
      sat_q  <= 1'b0;
    end else if (accept && is_mul) begin
      mcand  <= {{W{1'b0}}, ax};
      mplier <= ay;
      prod   <= '0;
      cnt    <= CW'(W);
      sgn    <= xb_dtx[W-1] ^ xb_dty[W-1];
      hi_q   <= (ps_alu_op == 4'hE);
      sat_q  <= ps_alu_sat;
    end else if (state == MUL) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

  // Result, flags, done pulse and sticky overflow.
  always_ff @(posedge clk_exe or negedge reset) begin
    if (!reset) begin
      alu_xb_dt    <= '0;
      alu_ps_done  <= 1'b0;
      alu_ps_az    <= 1'b0;
      alu_ps_an    <= 1'b0;
      alu_ps_ac    <= 1'b0;
      alu_ps_av    <= 1'b0;
      alu_ps_avs   <= 1'b0;
      alu_ps_compd <= 1'b0;
    end else begin
      alu_ps_done  <= 1'b0;
      alu_ps_compd <= 1'b0;
      if (upd) begin
        alu_xb_dt    <= n_res;
        alu_ps_done  <= 1'b1;
        alu_ps_az    <= n_zv && (n_res == '0);
        alu_ps_an    <= n_res[W-1];
        alu_ps_ac    <= n_ac;
        alu_ps_av    <= n_av;
        alu_ps_compd <= (state == IDLE) &&
                        (ps_alu_op == 4'h4);
      end
      if (ps_alu_clr)
        alu_ps_avs <= 1'b0;
      else if (upd && n_av)
        alu_ps_avs <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized bench for alu_seq against an
// arithmetic reference model, plus directed corner cases.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk_exe = 1'b0;
  logic         reset = 1'b0;
  logic         ps_alu_en = 1'b0;
  logic [3:0]   ps_alu_op = '0;
  logic         ps_alu_sat = 1'b0;
  logic         ps_alu_ci = 1'b0;
  logic         ps_alu_clr = 1'b0;
  logic [W-1:0] xb_dtx = '0;
  logic [W-1:0] xb_dty = '0;
  logic [W-1:0] alu_xb_dt;
  logic         alu_ps_done, alu_ps_busy;
  logic         alu_ps_az, alu_ps_an;
  logic         alu_ps_ac, alu_ps_av;
  logic         alu_ps_avs, alu_ps_compd;

  int   checks = 0;
  int   errors = 0;
  logic avs_m = 1'b0;

  alu_seq #(.DATA_WIDTH(W)) dut (
    .clk_exe      (clk_exe),
    .reset        (reset),
    .ps_alu_en    (ps_alu_en),
    .ps_alu_op    (ps_alu_op),
    .ps_alu_sat   (ps_alu_sat),
    .ps_alu_ci    (ps_alu_ci),
    .ps_alu_clr   (ps_alu_clr),
    .xb_dtx       (xb_dtx),
    .xb_dty       (xb_dty),
    .alu_xb_dt    (alu_xb_dt),
    .alu_ps_done  (alu_ps_done),
    .alu_ps_busy  (alu_ps_busy),
    .alu_ps_az    (alu_ps_az),
    .alu_ps_an    (alu_ps_an),
    .alu_ps_ac    (alu_ps_ac),
    .alu_ps_av    (alu_ps_av),
    .alu_ps_avs   (alu_ps_avs),
    .alu_ps_compd (alu_ps_compd)
  );

  always #5 clk_exe = ~clk_exe;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference: true signed/unsigned integer arithmetic.
  function automatic void model(
    input  logic [3:0]  op,
    input  logic [15:0] x, y,
    input  logic        ci, sat,
    output logic [15:0] r,
    output logic        az, an, ac, av);
    longint sx, sy, ux, uy, u, t, c;
    bit arith;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    c  = ci ? 1 : 0;
    r = '0; az = 0; an = 0; ac = 0; av = 0;
    u = 0; t = 0; arith = 0;
    case (op)
      4'h0: begin u = ux + uy; t = sx + sy; arith = 1; end
      4'h1: begin
        u = ux + (uy ^ 65535) + 1; t = sx - sy; arith = 1;
      end
      4'h2: begin u = ux + uy + c; t = sx + sy + c; arith = 1; end
      4'h3: begin
        u = ux + (uy ^ 65535) + c; t = sx - sy - 1 + c;
        arith = 1;
      end
      4'h7: begin u = (ux ^ 65535) + 1; t = -sx; arith = 1; end
      4'h8: begin
        if (sx < 0) begin u = (ux ^ 65535) + 1; t = -sx; end
        else begin u = ux; t = sx; end
        arith = 1;
      end
      4'h4: r = (sx < sy) ? 16'hFFFF : (sx == sy) ? 16'h0 : 16'h1;
      4'h5: r = (sx < sy) ? x : y;
      4'h6: r = (sx < sy) ? y : x;
      4'h9: r = x & y;
      4'hA: r = x | y;
      4'hB: r = x ^ y;
      4'hC: r = ~x;
      4'hD: begin
        t = sx * sy;
        av = (t > 32767) || (t < -32768);
        r = t[15:0];
        if (sat && av) r = (t > 0) ? 16'h7FFF : 16'h8000;
      end
      4'hE: begin t = sx * sy; r = t[31:16]; end
      default: return;
    endcase
    if (arith) begin
      r  = u[15:0];
      ac = u[16];
      av = (t > 32767) || (t < -32768);
      if (sat && av) r = (t > 0) ? 16'h7FFF : 16'h8000;
    end
    az = (r == 16'h0);
    an = r[15];
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic run_op(input logic [3:0]  op,
                        input logic [15:0] x, y,
                        input logic        ci, sat, clr,
                        input bit          inject);
    logic [15:0] er;
    logic eaz, ean, eac, eav;
    int n, bn;
    bit ismul;
    model(op, x, y, ci, sat, er, eaz, ean, eac, eav);
    ismul = (op == 4'hD) || (op == 4'hE);
    @(negedge clk_exe);
    ps_alu_op = op; xb_dtx = x; xb_dty = y;
    ps_alu_ci = ci; ps_alu_sat = sat; ps_alu_clr = clr;
    ps_alu_en = 1'b1;
    @(posedge clk_exe); #1;
    ps_alu_en = 1'b0; ps_alu_clr = 1'b0;
    n = 0; bn = 0;
    while (!alu_ps_done && n < 40) begin
      if (alu_ps_busy) bn++;
      if (inject && n == 5) begin
        ps_alu_en = 1'b1; ps_alu_op = 4'h0;
        xb_dtx = 16'h1234; xb_dty = 16'h1111;
      end
      if (inject && n == 6) ps_alu_en = 1'b0;
      @(posedge clk_exe); #1;
      n++;
    end
    if (clr) avs_m = 1'b0;
    if (!(clr && !ismul)) avs_m = avs_m | eav;
    chk("latency", n, ismul ? W + 1 : 0);
    chk("busy_cycles", bn, ismul ? W + 1 : 0);
    chk("busy_at_done", alu_ps_busy, 0);
    chk("dt", alu_xb_dt, er);
    chk("az", alu_ps_az, eaz);
    chk("an", alu_ps_an, ean);
    chk("ac", alu_ps_ac, eac);
    chk("av", alu_ps_av, eav);
    chk("avs", alu_ps_avs, avs_m);
    chk("compd", alu_ps_compd, op == 4'h4);
    @(posedge clk_exe); #1;
    chk("done_pulse", alu_ps_done, 0);
    chk("dt_hold", alu_xb_dt, er);
  endtask

  initial begin
    logic [15:0] er;
    logic eaz, ean, eac, eav;
    logic [3:0] op;
    int o;
    bit seen;

    #1;
    chk("rst_dt", alu_xb_dt, 0);
    chk("rst_flags", {alu_ps_az, alu_ps_an, alu_ps_ac,
                      alu_ps_av, alu_ps_avs}, 0);
    chk("rst_busy_done", {alu_ps_busy, alu_ps_done,
                          alu_ps_compd}, 0);
    repeat (2) @(negedge clk_exe);
    reset = 1'b1;

    run_op(4'h0, 16'h7FFF, 16'h0001, 0, 0, 0, 0);
    run_op(4'h0, 16'h7FFF, 16'h0001, 0, 1, 0, 0);
    run_op(4'h1, 16'h0005, 16'h0005, 0, 0, 0, 0);
    run_op(4'h4, 16'h8000, 16'h0001, 0, 0, 0, 0);
    run_op(4'h7, 16'h8000, 16'h0000, 0, 0, 0, 0);
    run_op(4'h8, 16'h8000, 16'h0000, 0, 1, 0, 0);
    run_op(4'hF, 16'h1234, 16'h5678, 0, 0, 0, 0);
    run_op(4'hD, 16'h0003, 16'hFFFB, 0, 0, 0, 0);
    run_op(4'hD, 16'h0100, 16'h0100, 0, 1, 0, 0);
    run_op(4'hE, 16'h0100, 16'h0100, 0, 0, 0, 0);
    run_op(4'hD, 16'h8000, 16'h8000, 0, 1, 0, 0);
    run_op(4'hE, 16'h8000, 16'h8000, 0, 0, 0, 0);
    run_op(4'hD, 16'h0007, 16'hFFF9, 0, 0, 0, 1);

    run_op(4'h0, 16'h7FFF, 16'h0001, 0, 0, 1, 0);
    run_op(4'h0, 16'h7FFF, 16'h0001, 0, 0, 0, 0);
    @(negedge clk_exe);
    ps_alu_clr = 1'b1;
    @(posedge clk_exe); #1;
    ps_alu_clr = 1'b0;
    avs_m = 1'b0;
    chk("clr_avs", alu_ps_avs, 0);

    run_op(4'h0, 16'h7FFF, 16'h0001, 0, 0, 0, 0);
    @(negedge clk_exe);
    ps_alu_op = 4'hD; xb_dtx = 16'h0123; xb_dty = 16'h0456;
    ps_alu_en = 1'b1;
    @(posedge clk_exe); #1;
    ps_alu_en = 1'b0;
    repeat (8) @(posedge clk_exe);
    #1;
    reset = 1'b0;
    #1;
    avs_m = 1'b0;
    chk("mrst_dt", alu_xb_dt, 0);
    chk("mrst_flags", {alu_ps_az, alu_ps_an, alu_ps_ac,
                       alu_ps_av, alu_ps_avs}, 0);
    chk("mrst_busy_done", {alu_ps_busy, alu_ps_done,
                           alu_ps_compd}, 0);
    @(negedge clk_exe);
    reset = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk_exe); #1;
      if (alu_ps_done || alu_ps_busy) seen = 1;
    end
    chk("no_ghost", seen, 0);
    run_op(4'h0, 16'h0001, 16'h0001, 0, 0, 0, 0);

    @(negedge clk_exe);
    for (int i = 0; i < 24; i++) begin
      o  = $urandom_range(0, 13);
      op = (o == 13) ? 4'hF : o[3:0];
      ps_alu_op = op; xb_dtx = pick(); xb_dty = pick();
      ps_alu_ci = 1'($urandom); ps_alu_sat = 1'($urandom);
      ps_alu_en = 1'b1;
      model(op, xb_dtx, xb_dty, ps_alu_ci, ps_alu_sat,
            er, eaz, ean, eac, eav);
      @(posedge clk_exe); #1;
      avs_m = avs_m | eav;
      chk("b2b_done", alu_ps_done, 1);
      chk("b2b_dt", alu_xb_dt, er);
      chk("b2b_flags", {alu_ps_az, alu_ps_an, alu_ps_ac,
                        alu_ps_av}, {eaz, ean, eac, eav});
      chk("b2b_avs", alu_ps_avs, avs_m);
    end
    ps_alu_en = 1'b0;

    for (int i = 0; i < 150; i++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick(),
             1'($urandom), 1'($urandom),
             ($urandom_range(0, 7) == 0), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
